store_buffer: RTL and testbench

//  Posted-write queue directly upstream of the data memory in the MEM stage.
//  - Stores from EX/MEM are accepted into a small FIFO and drained to data memory one word per cycle.
//  - Drains happen only in cycles with no load.
//  - Loads use the memory port with priority, and take data from the youngest matching buffered store when one exists.
//  - st_ready low means the buffer is full; the pipeline stalls on it.

---
 rtl/store_buffer_pkg.sv | 15 +
 rtl/store_buffer_if.sv | 28 ++
 rtl/store_buffer_fwd_select.sv | 35 +++
 rtl/store_buffer.sv | 127 ++++++++++++
 tb/tb_store_buffer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared width constants and types for the store buffer and data memory
package store_buffer_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  // Which client owns the data-memory port in the current cycle.
  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_DRAIN = 2'd1,
    MEM_LOAD  = 2'd2
  } mem_op_e;

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - pipeline-side store/load request interface of the store buffer
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) ();

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_fwd;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr,
    input  st_ready, ld_data, ld_fwd
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr,
    output st_ready, ld_data, ld_fwd
  );

endinterface

// File: rtl/store_buffer_fwd_select.sv
// rtl/store_buffer_fwd_select.sv - sb_fwd_select: youngest-first address match over buffered stores
module sb_fwd_select
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  valid_i,
  input  logic [ADDR_W-1:0] addr_i [DEPTH],
  input  logic [DATA_W-1:0] data_i [DEPTH],
  input  logic [PTR_W-1:0]  wr_ptr_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so a later (younger) match overrides an earlier one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr_i - PTR_W'(k);
      if (valid_i[idx] && (addr_i[idx] == ld_addr_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write FIFO in front of data memory with load forwarding
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  store_buffer_if.slave     sb_if,
  output logic              sb_empty_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_write_data_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic    full;
  logic    push;
  logic    pop;
  logic    fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  mem_op_e mem_op;

  // st_ready depends only on registered count, never on st_valid.
  assign full          = (count_q == CNT_W'(DEPTH));
  assign sb_empty_o    = (count_q == '0);
  assign sb_if.st_ready = !full;
  assign push          = sb_if.st_valid && !full;
  assign pop           = !sb_empty_o && !sb_if.ld_valid;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Entry payload needs no reset: valid_q alone qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= sb_if.st_addr;
      data_q[wr_ptr_q] <= sb_if.st_data;
    end
  end

  sb_fwd_select #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd_select (
    .valid_i   (valid_q),
    .addr_i    (addr_q),
    .data_i    (data_q),
    .wr_ptr_i  (wr_ptr_q),
    .ld_addr_i (sb_if.ld_addr),
    .hit_o     (fwd_hit),
    .data_o    (fwd_data)
  );

  assign sb_if.ld_fwd  = sb_if.ld_valid && fwd_hit;
  assign sb_if.ld_data = sb_if.ld_fwd ? fwd_data : mem_rdata_i;

  always_comb begin
    mem_op = MEM_IDLE;
    if (sb_if.ld_valid) begin
      mem_op = MEM_LOAD;
    end else if (!sb_empty_o) begin
      mem_op = MEM_DRAIN;
    end
  end

  always_comb begin
    mem_addr_o       = addr_q[rd_ptr_q];
    mem_write_data_o = data_q[rd_ptr_q];
    mem_write_o      = 1'b0;
    mem_read_o       = 1'b0;
    case (mem_op)
      MEM_LOAD: begin
        mem_addr_o = sb_if.ld_addr;
        mem_read_o = 1'b1;
      end
      MEM_DRAIN: mem_write_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed and random checks of store_buffer against a queue model
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        sb_empty;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] dut_mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] mq_addr [$];
  logic [31:0] mq_data [$];

  store_buffer_if sbif ();

  store_buffer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sb_if            (sbif.slave),
    .sb_empty_o       (sb_empty),
    .mem_addr_o       (mem_addr),
    .mem_write_data_o (mem_write_data),
    .mem_write_o      (mem_write),
    .mem_read_o       (mem_read),
    .mem_rdata_i      (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory, cleared by the same reset as the buffer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) dut_mem[i] <= '0;
    end else if (mem_write) begin
      dut_mem[mem_addr[3:0]] <= mem_write_data;
    end
  end
  assign mem_rdata = dut_mem[mem_addr[3:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    mq_addr.delete();
    mq_data.delete();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
  endtask

  task automatic compare_mem(input string tag);
    for (int i = 0; i < 16; i++) check(tag, dut_mem[i], ref_mem[i]);
  endtask

  // One cycle: drive inputs after the falling edge, check, then advance the model at the rising edge.
  task automatic step(input bit st_v, input logic [31:0] st_a, input logic [31:0] st_d,
                      input bit ld_v, input logic [31:0] ld_a);
    bit          exp_ready, exp_empty, exp_mw, exp_fwd;
    logic [31:0] exp_ld;
    sbif.st_valid = st_v;
    sbif.st_addr  = st_a;
    sbif.st_data  = st_d;
    sbif.ld_valid = ld_v;
    sbif.ld_addr  = ld_a;
    #1;
    exp_ready = (mq_addr.size() < 4);
    exp_empty = (mq_addr.size() == 0);
    exp_mw    = !exp_empty && !ld_v;
    check("st_ready", {31'd0, sbif.st_ready}, {31'd0, exp_ready});
    check("sb_empty", {31'd0, sb_empty}, {31'd0, exp_empty});
    check("mem_write", {31'd0, mem_write}, {31'd0, exp_mw});
    check("mem_read", {31'd0, mem_read}, {31'd0, ld_v});
    if (ld_v) begin
      exp_fwd = 1'b0;
      exp_ld  = ref_mem[ld_a[3:0]];
      for (int i = 0; i < mq_addr.size(); i++) begin
        if (mq_addr[i] == ld_a) begin
          exp_fwd = 1'b1;
          exp_ld  = mq_data[i];
        end
      end
      check("ld_fwd", {31'd0, sbif.ld_fwd}, {31'd0, exp_fwd});
      check("ld_data", sbif.ld_data, exp_ld);
      check("mem_addr_ld", mem_addr, ld_a);
    end else begin
      check("ld_fwd_idle", {31'd0, sbif.ld_fwd}, 32'd0);
      if (!exp_empty) begin
        check("mem_addr_drain", mem_addr, mq_addr[0]);
        check("mem_wdata", mem_write_data, mq_data[0]);
      end
    end
    @(posedge clk);
    if (exp_mw) begin
      ref_mem[mq_addr[0][3:0]] = mq_data[0];
      void'(mq_addr.pop_front());
      void'(mq_data.pop_front());
    end
    if (st_v && exp_ready) begin
      mq_addr.push_back(st_a);
      mq_data.push_back(st_d);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    sbif.st_valid = 1'b0;
    sbif.ld_valid = 1'b0;
    #1;
    check("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
    check("rst_st_ready", {31'd0, sbif.st_ready}, 32'd1);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_ld_fwd", {31'd0, sbif.ld_fwd}, 32'd0);
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit          hold_done;
    sbif.st_valid = 1'b0;
    sbif.st_addr  = '0;
    sbif.st_data  = '0;
    sbif.ld_valid = 1'b0;
    sbif.ld_addr  = '0;
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset mid-drain: queued stores are discarded and never reach memory.
    step(1'b1, 32'd1, 32'h101, 1'b1, 32'd15);
    step(1'b1, 32'd2, 32'h202, 1'b1, 32'd15);
    step(1'b1, 32'd4, 32'h404, 1'b1, 32'd15);
    step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    do_reset();
    idle(4);
    compare_mem("mem_after_reset");

    // Single store, drained the next cycle.
    step(1'b1, 32'd5, 32'hAAAA5555, 1'b0, 32'd0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    idle(1);
    check("mem5", dut_mem[5], 32'hAAAA5555);

    // Youngest duplicate is forwarded and ends in memory.
    step(1'b1, 32'd3, 32'h11, 1'b0, 32'd0);
    step(1'b1, 32'd3, 32'h22, 1'b0, 32'd0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 32'd3);
    idle(3);
    check("mem3", dut_mem[3], 32'h22);

    // Fill while loads hold the port, then hold the fifth store until accepted.
    for (int i = 0; i < 5; i++) step(1'b1, 32'(8 + i), 32'hC0 + 32'(i), 1'b1, 32'd14);
    hold_done = 1'b0;
    for (int n = 0; n < 8 && !hold_done; n++) begin
      hold_done = (mq_addr.size() < 4);
      step(1'b1, 32'd12, 32'hC4, 1'b0, 32'd0);
    end
    check("held_store_accepted", {31'd0, hold_done}, 32'd1);
    idle(6);
    compare_mem("mem_fill");

    // Load miss with a different address buffered.
    step(1'b1, 32'd6, 32'h66, 1'b1, 32'd2);
    step(1'b0, 32'd0, 32'd0, 1'b1, 32'd7);
    idle(2);

    // Pointer wrap with back-to-back stores.
    for (int i = 0; i < 10; i++) step(1'b1, 32'(i), 32'hD00 + 32'(i), 1'b0, 32'd0);
    idle(2);
    compare_mem("mem_wrap");

    // Random mix of stores and loads over a small address space.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 55), 32'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 99) < 40), 32'($urandom_range(0, 15)));
    end
    idle(6);
    compare_mem("mem_random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
